// File: rtl/io_port_if.sv
// Port-side bundle between the processor/host and io_port_peripheral.
// slave = the peripheral, master = whoever drives the processor and host sides.
interface io_port_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] outputPort;
  logic              out_wr;
  logic [DATA_W-1:0] inputPort;
  logic              in_rd;
  logic              interrupt;
  logic              irq_en;
  logic [DATA_W-1:0] host_rd_data;
  logic              host_rd_valid;
  logic              host_rd_ready;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic              tx_ovf;

  modport slave (
    input  outputPort, out_wr, in_rd, irq_en, host_rd_ready, host_wr_data, host_wr_valid,
    output inputPort, interrupt, host_rd_data, host_rd_valid, host_wr_ready, tx_ovf
  );

  modport master (
    output outputPort, out_wr, in_rd, irq_en, host_rd_ready, host_wr_data, host_wr_valid,
    input  inputPort, interrupt, host_rd_data, host_rd_valid, host_wr_ready, tx_ovf
  );
endinterface

// File: rtl/io_port_peripheral.sv
// Processor-side I/O peer: TX FIFO (processor -> host), RX FIFO (host -> processor), pulsed IRQ.
// Optional IO_PEER_LOOPBACK_EN adds a loopback input that moves TX head words into the RX FIFO.
module io_port_peripheral #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int IRQ_PULSE  = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef IO_PEER_LOOPBACK_EN
  input  logic loopback,
`endif
  io_port_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(IRQ_PULSE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT} irq_state_e;

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] tx_mem_q, tx_mem_d, rx_mem_q, rx_mem_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic          tx_ovf_q, tx_ovf_d;
  irq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop_host, tx_pop, tx_push;
  logic rx_pop, rx_push_host, rx_push, lb_xfer;
  logic [DATA_W-1:0] tx_head, rx_head, rx_push_data;

  // Extra MSB on the pointers separates full from empty when the index bits match.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[PW-1] != tx_rd_q[PW-1]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[PW-1] != rx_rd_q[PW-1]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_head  = tx_mem_q[tx_rd_q[AW-1:0]];
  assign rx_head  = rx_mem_q[rx_rd_q[AW-1:0]];

  always_comb begin
    tx_pop_host  = bus.host_rd_ready & ~tx_empty;
    rx_pop       = bus.in_rd & ~rx_empty;
    rx_push_host = bus.host_wr_valid & (~rx_full | rx_pop);
`ifdef IO_PEER_LOOPBACK_EN
    // Loopback only uses idle FIFO ports: host pop and host push both win over it.
    lb_xfer      = loopback & ~tx_empty & ~tx_pop_host & ~rx_full & ~rx_push_host;
`else
    lb_xfer      = 1'b0;
`endif
    tx_pop       = tx_pop_host | lb_xfer;
    tx_push      = bus.out_wr & (~tx_full | tx_pop);
    rx_push      = rx_push_host | lb_xfer;
    rx_push_data = rx_push_host ? bus.host_wr_data : tx_head;

    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push) tx_mem_d[tx_wr_q[AW-1:0]] = bus.outputPort;
    if (rx_push) rx_mem_d[rx_wr_q[AW-1:0]] = rx_push_data;

    tx_wr_d  = tx_push ? tx_wr_q + PW'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + PW'(1) : tx_rd_q;
    rx_wr_d  = rx_push ? rx_wr_q + PW'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + PW'(1) : rx_rd_q;
    tx_ovf_d = tx_ovf_q | (bus.out_wr & tx_full & ~tx_pop);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.irq_en && !rx_empty) begin
          state_d = ST_PULSE;
          cnt_d   = '0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == CW'(IRQ_PULSE - 1)) state_d = ST_WAIT;
        else                             cnt_d   = cnt_q + CW'(1);
      end
      ST_WAIT: begin
        if (rx_pop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_ovf_q <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_ovf_q <= tx_ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.inputPort     = rx_empty ? '0 : rx_head;
  assign bus.host_rd_data  = tx_empty ? '0 : tx_head;
  assign bus.host_rd_valid = ~tx_empty;
  assign bus.host_wr_ready = ~rx_full;
  assign bus.interrupt     = (state_q == ST_PULSE);
  assign bus.tx_ovf        = tx_ovf_q;
endmodule
